mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_if_pkg.sv | 43 ++++
 rtl/mem_timeout_ctr.sv | 36 +++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions: control-unit opcodes/states, memory FSM states, timeout default.
// Pure declarations, no logic and no latency.
package mem_if_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_OPIMM  = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        CU_FETCH,
        CU_DECODE,
        CU_EXEC,
        CU_MEM,
        CU_WB
    } cu_state_e;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_REQ,
        MS_WAIT,
        MS_DONE
    } mem_state_e;

    // Transaction fields frozen at capture time.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        to_ir;
    } mem_txn_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles while enabled; flags expiry in the TIMEOUT-th enabled cycle.
// Expiry is combinational on the count; clear has priority over enable.
// No backpressure: the owner decides when to clear.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired = enable && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle-CPU memory port: captures one load/store, runs req/gnt then rvalid, fills ir or mdr.
// Latency: read >= 3 cycles (capture, gnt, rvalid), write >= 2; DONE lasts one cycle.
// Backpressure: mem_stall holds the control unit until DONE; mem_req held until mem_gnt or timeout.
module mem_access_unit
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        i_or_d,
    input  logic        ir_write,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] b_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic        mem_stall,
    output logic        mem_err
);

    mem_state_e  state_q,   state_d;
    mem_txn_t    txn_q,     txn_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q,  mem_we_d;
    logic [31:0] ir_q,      ir_d;
    logic [31:0] mdr_q,     mdr_d;
    logic        err_q,     err_d;

    logic [31:0] sel_addr;
    logic        tmo_en;
    logic        tmo_expired;

    assign tmo_en = (state_q == MS_REQ) || (state_q == MS_WAIT);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .enable  (tmo_en),
        .clear   (!tmo_en),
        .expired (tmo_expired)
    );

    assign sel_addr  = i_or_d ? alu_out : pc;
    assign mem_stall = (mem_read || mem_write) && (state_q != MS_DONE);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = txn_q.addr;
    assign mem_wdata = txn_q.wdata;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign mem_err   = err_q;

    always_comb begin
        state_d   = state_q;
        txn_d     = txn_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        err_d     = err_q;

        unique case (state_q)
            MS_IDLE: begin
                if (mem_read && mem_write) begin
                    err_d   = 1'b1;
                    state_d = MS_DONE;
                end else if (mem_read || mem_write) begin
                    if (!word_aligned(sel_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = MS_DONE;
                    end else begin
                        txn_d.addr  = sel_addr;
                        txn_d.wdata = b_data;
                        txn_d.we    = mem_write;
                        txn_d.to_ir = ir_write;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        state_d     = MS_REQ;
                    end
                end
            end
            MS_REQ: begin
                // A write finishes on gnt even in the expiring cycle; a read still owes rvalid, so expiry wins.
                if (mem_gnt && txn_q.we) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = MS_DONE;
                end else if (tmo_expired) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = MS_DONE;
                end else if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = MS_WAIT;
                end
            end
            MS_WAIT: begin
                if (mem_rvalid) begin
                    if (txn_q.to_ir) begin
                        ir_d = mem_rdata;
                    end else begin
                        mdr_d = mem_rdata;
                    end
                    state_d = MS_DONE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = MS_DONE;
                end
            end
            MS_DONE: begin
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= MS_IDLE;
            txn_q     <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            ir_q      <= '0;
            mdr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            txn_q     <= txn_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level timeline model, per-cycle compare, literal pins.
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, i_or_d, ir_write;
    logic [31:0] pc, alu_out, b_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] ir, mdr;
    logic        mem_stall, mem_err;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc         (pc),
        .alu_out    (alu_out),
        .b_data     (b_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .mdr        (mdr),
        .mem_stall  (mem_stall),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int req_cnt = 0;
    bit chk_en = 1'b0;

    // Model state: architectural values the DUT must show this cycle.
    logic [31:0] m_addr, m_wdata, m_ir, m_mdr;
    logic        m_err;
    logic        exp_req, exp_we, exp_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   32'(mem_req),   32'(exp_req));
            chk("mem_we",    32'(mem_we),    32'(exp_we));
            chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
            chk("mem_err",   32'(mem_err),   32'(m_err));
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("ir",        ir,        m_ir);
            chk("mdr",       mdr,       m_mdr);
            if (mem_req === 1'b1) req_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_addr = '0; m_wdata = '0; m_ir = '0; m_mdr = '0; m_err = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        cyc();
        model_clear();
        chk_en = 1'b1;
        cyc();
        reset = 1'b1;
    endtask

    task automatic gap(input int n);
        mem_read = 1'b0; mem_write = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom();
            cyc();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // g: REQ cycles before gnt; r: WAIT cycles before rvalid. Cycle k=0 is the capture cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic iod, input logic irw,
                           input logic [31:0] pcv, input logic [31:0] aluv, input logic [31:0] bdv,
                           input int g, input int r, input logic [31:0] rdv);
        logic [31:0] a;
        bit illegal, comp, err;
        int kgnt, kval, kdone, req_end;
        a = iod ? aluv : pcv;
        illegal = (rd && wr) || (a[1:0] != 2'b00);
        kgnt = 1 + g;
        kval = 2 + g + r;
        comp = 1'b0; err = 1'b0;
        if (illegal) begin
            kdone = 1; req_end = 0; err = 1'b1;
        end else if (wr) begin
            if (kgnt <= TO) begin req_end = kgnt; kdone = kgnt + 1; comp = 1'b1; end
            else begin req_end = TO; kdone = TO + 1; err = 1'b1; end
        end else begin
            if (kgnt <= TO - 1) begin
                req_end = kgnt;
                if (kval <= TO) begin kdone = kval + 1; comp = 1'b1; end
                else begin kdone = TO + 1; err = 1'b1; end
            end else begin
                req_end = TO; kdone = TO + 1; err = 1'b1;
            end
        end

        req_cnt = 0;
        for (int k = 0; k <= kdone; k++) begin
            if (k == 0) begin
                pc = pcv; alu_out = aluv; b_data = bdv; i_or_d = iod; ir_write = irw;
            end else begin
                pc = $urandom(); alu_out = $urandom(); b_data = $urandom();
                i_or_d = 1'($urandom_range(0, 1)); ir_write = 1'($urandom_range(0, 1));
            end
            mem_read = rd; mem_write = wr;
            if (k == kgnt)                 mem_gnt = 1'b1;
            else if (k == 0 || k > kgnt)   mem_gnt = 1'($urandom_range(0, 1));
            else                           mem_gnt = 1'b0;
            if (k == kval)                 mem_rvalid = 1'b1;
            else if (k <= kgnt)            mem_rvalid = 1'($urandom_range(0, 1));
            else                           mem_rvalid = 1'b0;
            mem_rdata = (k == kval) ? rdv : $urandom();

            if (k == 1 && !illegal) begin m_addr = a; m_wdata = bdv; end
            if (k == kdone) begin
                if (err) m_err = 1'b1;
                if (comp && rd) begin
                    if (irw) m_ir = rdv;
                    else     m_mdr = rdv;
                end
            end
            exp_req   = (k >= 1) && (k <= req_end);
            exp_we    = exp_req && wr;
            exp_stall = (k < kdone);
            cyc();
        end
        gap(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; i_or_d = 1'b0; ir_write = 1'b0;
        pc = '0; alu_out = '0; b_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_clear();
        do_reset();
        gap(2);

        // Fetch: gnt in cycle 1, rvalid in cycle 2, ir valid in cycle 3
        run_txn(1, 0, 0, 1, 32'h100, 32'h0, 32'h0, 0, 0, 32'h00500093);
        chk("pin_fetch_ir",  ir,  32'h00500093);
        chk("pin_fetch_mdr", mdr, 32'h0);
        chk("pin_fetch_req_cycles", 32'(req_cnt), 32'd1);

        // Store with gnt on the 4th request cycle
        run_txn(0, 1, 1, 0, 32'h0, 32'h204, 32'hCAFEF00D, 3, 0, 32'h0);
        chk("pin_store_req_cycles", 32'(req_cnt), 32'd4);
        chk("pin_store_addr",  mem_addr,  32'h204);
        chk("pin_store_wdata", mem_wdata, 32'hCAFEF00D);
        chk("pin_store_err",   32'(mem_err), 32'd0);

        // Misaligned load
        run_txn(1, 0, 1, 0, 32'h0, 32'h203, 32'h0, 0, 0, 32'hDEADBEEF);
        chk("pin_misalign_req_cycles", 32'(req_cnt), 32'd0);
        chk("pin_misalign_err", 32'(mem_err), 32'd1);
        chk("pin_misalign_mdr", mdr, 32'h0);

        // Reset while waiting for read data, then a late rvalid
        mem_read = 1'b1; mem_write = 1'b0; i_or_d = 1'b0; ir_write = 1'b1; pc = 32'h400;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b1;
        cyc();
        m_addr = 32'h400; m_wdata = b_data;
        mem_gnt = 1'b1; exp_req = 1'b1;
        cyc();
        mem_gnt = 1'b0; exp_req = 1'b0; reset = 1'b0;
        cyc();
        reset = 1'b1; mem_read = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        model_clear();
        cyc();
        mem_rvalid = 1'b0;
        cyc();
        chk("pin_rst_ir",   ir,  32'h0);
        chk("pin_rst_mdr",  mdr, 32'h0);
        chk("pin_rst_err",  32'(mem_err), 32'd0);
        chk("pin_rst_addr", mem_addr, 32'h0);

        // Write that never gets a grant
        run_txn(0, 1, 1, 0, 32'h0, 32'h80, 32'h11112222, 40, 0, 32'h0);
        chk("pin_tmo_req_cycles", 32'(req_cnt), 32'd8);
        chk("pin_tmo_err", 32'(mem_err), 32'd1);

        // Both strobes high, then a normal load to mdr
        do_reset();
        gap(1);
        run_txn(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("pin_both_req_cycles", 32'(req_cnt), 32'd0);
        chk("pin_both_err", 32'(mem_err), 32'd1);
        run_txn(1, 0, 1, 0, 32'h0, 32'h300, 32'h0, 1, 2, 32'hA5A50001);
        chk("pin_after_err_mdr", mdr, 32'hA5A50001);
        chk("pin_after_err_err", 32'(mem_err), 32'd1);

        // Randomized traffic
        do_reset();
        gap(1);
        for (int n = 0; n < 250; n++) begin
            int sel, g, r;
            logic rd, wr, iod;
            logic [31:0] pcv, aluv;
            sel = $urandom_range(0, 9);
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd;
            iod = 1'($urandom_range(0, 1));
            pcv  = $urandom() & 32'hFFFF_FFFC;
            aluv = $urandom() & 32'hFFFF_FFFC;
            if (sel == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else if (sel == 1) begin
                pcv  = pcv  | 32'($urandom_range(1, 3));
                aluv = aluv | 32'($urandom_range(1, 3));
            end
            g = ($urandom_range(0, 6) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
            r = ($urandom_range(0, 6) == 0) ? $urandom_range(3, 9)  : $urandom_range(0, 2);
            if (n == 125) begin
                do_reset();
                gap(1);
            end
            run_txn(rd, wr, iod, 1'($urandom_range(0, 1)), pcv, aluv, $urandom(), g, r, $urandom());
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
